// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
// Round-robin arbiter sharing the single L2 port between the L1 I-cache miss
// path and the L1 D-cache miss/write-through path. One requester's command is
// latched onto the L2 port and held until L2 acknowledges. The returned line
// then goes back to that requester with a one-cycle ack pulse.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ic_req_i, ic_addr_i      I-side line read request (level) and address
//   ic_ack_o, ic_rdata_o     I-side completion pulse and returned line
//   dc_req_i, dc_we_i,       D-side request (level), write flag, address,
//   dc_addr_i, dc_wdata_i    and write line
//   dc_ack_o, dc_rdata_o     D-side completion pulse and returned line
//   l2_req_o, l2_we_o,       registered command to L2, held until l2_ack_i
//   l2_addr_o, l2_wdata_o
//   l2_ack_i, l2_rdata_i     L2 one-cycle completion and read line
//   busy_o                   high whenever a transaction is in flight
//   ic_grant_cnt_o,          wrapping per-requester grant counters
//   dc_grant_cnt_o
module l2_req_arbiter #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              l2_req_o,
  output logic              l2_we_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [LINE_W-1:0] l2_wdata_o,
  input  logic              l2_ack_i,
  input  logic [LINE_W-1:0] l2_rdata_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  ic_grant_cnt_o,
  output logic [CNT_W-1:0]  dc_grant_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e              state_q, state_d;
  logic                own_q, own_d;
  logic                last_q, last_d;
  logic                l2_req_q, l2_req_d;
  logic                l2_we_q, l2_we_d;
  logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
  logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;
  logic                ic_ack_q, ic_ack_d;
  logic                dc_ack_q, dc_ack_d;
  logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    ic_cnt_q, ic_cnt_d;
  logic [CNT_W-1:0]    dc_cnt_q, dc_cnt_d;

  logic                any_req;
  logic                grant_dc;

  assign any_req  = ic_req_i | dc_req_i;
  // DC wins when it is alone, or on a tie when IC was granted last.
  assign grant_dc = dc_req_i & (~ic_req_i | ~last_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)  state_d = REQ;
      REQ:     if (l2_ack_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a register; this block computes their next values.
  // l2_req/busy are derived from the next state so they line up with it.
  always_comb begin
    own_d      = own_q;
    last_d     = last_q;
    l2_we_d    = l2_we_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    ic_ack_d   = 1'b0;
    dc_ack_d   = 1'b0;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_cnt_d   = ic_cnt_q;
    dc_cnt_d   = dc_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          own_d  = grant_dc;
          last_d = grant_dc;
          if (grant_dc) begin
            l2_we_d    = dc_we_i;
            l2_addr_d  = dc_addr_i;
            l2_wdata_d = dc_wdata_i;
            dc_cnt_d   = dc_cnt_q + CNT_W'(1);
          end else begin
            l2_we_d    = 1'b0;
            l2_addr_d  = ic_addr_i;
            l2_wdata_d = '0;
            ic_cnt_d   = ic_cnt_q + CNT_W'(1);
          end
        end
      end
      REQ: begin
        // Writes also capture the returned line into the owner's register.
        if (l2_ack_i) begin
          if (own_q) begin
            dc_rdata_d = l2_rdata_i;
            dc_ack_d   = 1'b1;
          end else begin
            ic_rdata_d = l2_rdata_i;
            ic_ack_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    l2_req_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_q      <= 1'b0;
      last_q     <= 1'b1;
      l2_req_q   <= 1'b0;
      l2_we_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      busy_q     <= 1'b0;
      ic_cnt_q   <= '0;
      dc_cnt_q   <= '0;
    end else begin
      own_q      <= own_d;
      last_q     <= last_d;
      l2_req_q   <= l2_req_d;
      l2_we_q    <= l2_we_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      ic_ack_q   <= ic_ack_d;
      dc_ack_q   <= dc_ack_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      busy_q     <= busy_d;
      ic_cnt_q   <= ic_cnt_d;
      dc_cnt_q   <= dc_cnt_d;
    end
  end

  assign ic_ack_o       = ic_ack_q;
  assign ic_rdata_o     = ic_rdata_q;
  assign dc_ack_o       = dc_ack_q;
  assign dc_rdata_o     = dc_rdata_q;
  assign l2_req_o       = l2_req_q;
  assign l2_we_o        = l2_we_q;
  assign l2_addr_o      = l2_addr_q;
  assign l2_wdata_o     = l2_wdata_q;
  assign busy_o         = busy_q;
  assign ic_grant_cnt_o = ic_cnt_q;
  assign dc_grant_cnt_o = dc_cnt_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter
// Scoreboard bench for l2_req_arbiter. Requester agents and an L2 responder
// drive the inputs on the falling edge; a monitor pops expected grants and
// responses whenever the DUT raises l2_req_o or an ack.
module tb_l2_req_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;
  localparam int CW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } grant_t;

  typedef struct {
    logic          side;
    logic [LW-1:0] rdata;
  } resp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } dccmd_t;

  logic          clk_i;
  logic          rst_ni;
  logic          ic_req_i;
  logic [AW-1:0] ic_addr_i;
  logic          ic_ack_o;
  logic [LW-1:0] ic_rdata_o;
  logic          dc_req_i;
  logic          dc_we_i;
  logic [AW-1:0] dc_addr_i;
  logic [LW-1:0] dc_wdata_i;
  logic          dc_ack_o;
  logic [LW-1:0] dc_rdata_o;
  logic          l2_req_o;
  logic          l2_we_o;
  logic [AW-1:0] l2_addr_o;
  logic [LW-1:0] l2_wdata_o;
  logic          l2_ack_i;
  logic [LW-1:0] l2_rdata_i;
  logic          busy_o;
  logic [CW-1:0] ic_grant_cnt_o;
  logic [CW-1:0] dc_grant_cnt_o;

  grant_t        expGrantQ[$];
  resp_t         expRespQ[$];
  logic [LW-1:0] l2DataQ[$];
  logic [AW-1:0] icCmdQ[$];
  dccmd_t        dcCmdQ[$];

  int            numCompared;
  int            numMismatched;
  logic          randomMode;
  logic          l2Manual;
  logic          manualAck;
  logic [LW-1:0] manualData;
  int            l2Lat;

  l2_req_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .ic_ack_o(ic_ack_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
    .l2_req_o(l2_req_o), .l2_we_o(l2_we_o), .l2_addr_o(l2_addr_o),
    .l2_wdata_o(l2_wdata_o), .l2_ack_i(l2_ack_i), .l2_rdata_i(l2_rdata_i),
    .busy_o(busy_o), .ic_grant_cnt_o(ic_grant_cnt_o),
    .dc_grant_cnt_o(dc_grant_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request to a requester agent.
  task automatic applyStimulus(input logic side, input logic we,
                               input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    dccmd_t c;
    if (side) begin
      c.we = we; c.addr = addr; c.wdata = wdata;
      dcCmdQ.push_back(c);
    end else begin
      icCmdQ.push_back(addr);
    end
  endtask

  // Record the hand-computed L2 command and response for one transaction.
  task automatic expectTxn(input logic side, input logic we, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    grant_t g;
    resp_t  r;
    g.we = we; g.addr = addr; g.wdata = wdata;
    r.side = side; r.rdata = rdata;
    expGrantQ.push_back(g);
    expRespQ.push_back(r);
    l2DataQ.push_back(rdata);
  endtask

  function automatic logic anyOutput();
    return l2_req_o | l2_we_o | (|l2_addr_o) | (|l2_wdata_o) | ic_ack_o | dc_ack_o |
           (|ic_rdata_o) | (|dc_rdata_o) | busy_o | (|ic_grant_cnt_o) | (|dc_grant_cnt_o);
  endfunction

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(expGrantQ.size() == 0 && expRespQ.size() == 0 && icCmdQ.size() == 0 &&
             dcCmdQ.size() == 0 && !ic_req_i && !dc_req_i && !busy_o) && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    @(posedge clk_i);
    #1;
    checkOutput("idle_within_budget", LW'(n < budget), LW'(1));
    if (n >= budget) begin
      expGrantQ.delete(); expRespQ.delete(); l2DataQ.delete();
      icCmdQ.delete(); dcCmdQ.delete();
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // I-side agent: raise a request, drop it in the cycle after its ack.
  initial begin
    ic_req_i = 1'b0;
    ic_addr_i = '0;
    forever begin
      @(negedge clk_i);
      if (randomMode) begin
        ic_req_i = 1'($urandom);
        ic_addr_i = $urandom;
      end else if (!rst_ni) begin
        ic_req_i = 1'b0;
        ic_addr_i = '0;
      end else if (ic_req_i) begin
        if (ic_ack_o) ic_req_i = 1'b0;
      end else if (icCmdQ.size() > 0) begin
        ic_addr_i = icCmdQ.pop_front();
        ic_req_i = 1'b1;
      end
    end
  end

  // D-side agent.
  initial begin
    dccmd_t c;
    dc_req_i = 1'b0;
    dc_we_i = 1'b0;
    dc_addr_i = '0;
    dc_wdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (randomMode) begin
        dc_req_i = 1'($urandom);
        dc_we_i = 1'($urandom);
        dc_addr_i = $urandom;
        dc_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      end else if (!rst_ni) begin
        dc_req_i = 1'b0;
        dc_we_i = 1'b0;
        dc_addr_i = '0;
        dc_wdata_i = '0;
      end else if (dc_req_i) begin
        if (dc_ack_o) dc_req_i = 1'b0;
      end else if (dcCmdQ.size() > 0) begin
        c = dcCmdQ.pop_front();
        dc_we_i = c.we;
        dc_addr_i = c.addr;
        dc_wdata_i = c.wdata;
        dc_req_i = 1'b1;
      end
    end
  end

  // L2 responder: ack l2Lat cycles into the request, or follow manual controls.
  initial begin
    int cnt = 0;
    l2_ack_i = 1'b0;
    l2_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (randomMode) begin
        l2_ack_i = 1'($urandom);
        l2_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end else if (l2Manual) begin
        l2_ack_i = manualAck;
        l2_rdata_i = manualData;
      end else begin
        l2_ack_i = 1'b0;
        if (l2_req_o) begin
          cnt++;
          if (cnt == l2Lat) begin
            l2_ack_i = 1'b1;
            l2_rdata_i = (l2DataQ.size() > 0) ? l2DataQ.pop_front() : '0;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compare the L2 command every request cycle, and each ack pulse.
  initial begin
    grant_t cur;
    resp_t  r;
    logic   haveCur = 1'b0;
    logic   prevReq = 1'b0;
    logic   prevIcAck = 1'b0;
    logic   prevDcAck = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        haveCur = 1'b0; prevReq = 1'b0; prevIcAck = 1'b0; prevDcAck = 1'b0;
      end else begin
        if (l2_req_o && !prevReq) begin
          if (expGrantQ.size() == 0) begin
            checkOutput("unexpected_grant_addr", LW'(l2_addr_o), '0);
            haveCur = 1'b0;
          end else begin
            cur = expGrantQ.pop_front();
            haveCur = 1'b1;
          end
        end
        if (l2_req_o && haveCur) begin
          checkOutput("l2_addr", LW'(l2_addr_o), LW'(cur.addr));
          checkOutput("l2_we", LW'(l2_we_o), LW'(cur.we));
          checkOutput("l2_wdata", l2_wdata_o, cur.wdata);
        end
        if (ic_ack_o || dc_ack_o) begin
          if (expRespQ.size() == 0) begin
            checkOutput("unexpected_ack", LW'({dc_ack_o, ic_ack_o}), '0);
          end else begin
            r = expRespQ.pop_front();
            checkOutput("ack_side", LW'({dc_ack_o, ic_ack_o}), r.side ? LW'(2) : LW'(1));
            checkOutput("ack_rdata", r.side ? dc_rdata_o : ic_rdata_o, r.rdata);
          end
          checkOutput("ack_single_cycle", LW'((ic_ack_o & prevIcAck) | (dc_ack_o & prevDcAck)), '0);
        end
        prevReq = l2_req_o;
        prevIcAck = ic_ack_o;
        prevDcAck = dc_ack_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [LW-1:0] D1 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
  localparam logic [LW-1:0] D2 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [LW-1:0] D3 = 128'h5A5A_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [LW-1:0] D4 = 128'h1000_0000_0000_0000_0000_0000_0000_0100;
  localparam logic [LW-1:0] D5 = 128'h2000_0000_0000_0000_0000_0000_0000_0200;
  localparam logic [LW-1:0] WA5 = {16{8'hA5}};
  localparam logic [LW-1:0] WCF = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1234_5678;

  initial begin
    numCompared = 0;
    numMismatched = 0;
    rst_ni = 1'b0;
    randomMode = 1'b1;
    l2Manual = 1'b0;
    manualAck = 1'b0;
    manualData = '0;
    l2Lat = 3;

    // Reset held with random inputs: every output stays zero.
    repeat (6) begin
      @(posedge clk_i);
      #1;
      checkOutput("reset_outputs_zero", LW'(anyOutput()), '0);
    end
    randomMode = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // First request after reset from DC only.
    l2Lat = 2;
    expectTxn(1'b1, 1'b0, 32'h0000_3000, '0, D1);
    applyStimulus(1'b1, 1'b0, 32'h0000_3000, '0);
    waitIdle(50);
    checkOutput("first_dc_cnt", LW'(dc_grant_cnt_o), LW'(1));
    checkOutput("first_ic_cnt", LW'(ic_grant_cnt_o), LW'(0));

    // Single IC read, L2 acks on the third request cycle.
    l2Lat = 3;
    expectTxn(1'b0, 1'b0, 32'h0000_1040, '0, D2);
    applyStimulus(1'b0, 1'b0, 32'h0000_1040, '0);
    waitIdle(50);

    // DC write of an all-0xA5 line.
    l2Lat = 2;
    expectTxn(1'b1, 1'b1, 32'h0000_2000, WA5, D3);
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, WA5);
    waitIdle(50);
    checkOutput("ic_rdata_held", ic_rdata_o, D2);
    checkOutput("dc_rdata_held", dc_rdata_o, D3);
    checkOutput("seq_ic_cnt", LW'(ic_grant_cnt_o), LW'(1));
    checkOutput("seq_dc_cnt", LW'(dc_grant_cnt_o), LW'(2));

    // First tie after reset goes to IC, then DC; minimum service latency.
    doReset();
    l2Lat = 1;
    expectTxn(1'b0, 1'b0, 32'h0000_0100, '0, D4);
    expectTxn(1'b1, 1'b0, 32'h0000_0200, '0, D5);
    applyStimulus(1'b0, 1'b0, 32'h0000_0100, '0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, '0);
    waitIdle(100);
    checkOutput("tie_ic_cnt", LW'(ic_grant_cnt_o), LW'(1));
    checkOutput("tie_dc_cnt", LW'(dc_grant_cnt_o), LW'(1));

    // Fairness: both keep re-requesting, grants alternate IC, DC, IC, DC.
    doReset();
    l2Lat = 2;
    expectTxn(1'b0, 1'b0, 32'h0000_0400, '0, D1);
    expectTxn(1'b1, 1'b1, 32'h0000_0800, WCF, D2);
    expectTxn(1'b0, 1'b0, 32'h0000_0440, '0, D3);
    expectTxn(1'b1, 1'b0, 32'h0000_0840, '0, D4);
    applyStimulus(1'b0, 1'b0, 32'h0000_0400, '0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0440, '0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0800, WCF);
    applyStimulus(1'b1, 1'b0, 32'h0000_0840, '0);
    waitIdle(200);
    checkOutput("fair_ic_cnt", LW'(ic_grant_cnt_o), LW'(2));
    checkOutput("fair_dc_cnt", LW'(dc_grant_cnt_o), LW'(2));

    // Reset in the middle of a request, then a late L2 ack.
    doReset();
    l2Lat = 1000;
    begin
      grant_t g;
      int n = 0;
      g.we = 1'b0; g.addr = 32'h0000_0500; g.wdata = '0;
      expGrantQ.push_back(g);
      applyStimulus(1'b0, 1'b0, 32'h0000_0500, '0);
      while (!l2_req_o && n < 20) begin
        @(posedge clk_i);
        n++;
      end
      #1;
      checkOutput("midreq_l2_req_seen", LW'(l2_req_o), LW'(1));
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("midreq_outputs_zero", LW'(anyOutput()), '0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    l2Manual = 1'b1;
    manualData = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    @(posedge clk_i);
    manualAck = 1'b1;
    @(posedge clk_i);
    manualAck = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("late_ack_outputs_zero", LW'(anyOutput()), '0);
    checkOutput("late_ack_grant_drained", LW'(expGrantQ.size()), '0);
    l2Manual = 1'b0;
    l2Lat = 3;
    repeat (2) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
